// File: rtl/ahb_switch_event_pkg.sv
// ahb_switch_event_pkg: register offsets and CTRL/STATUS bit positions shared with firmware headers
package ahb_switch_event_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_LEVEL = 2'd3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;
  localparam int CTRL_FALL_EN = 2;
  localparam int STATUS_EMPTY = 0;
  localparam int STATUS_FULL = 1;
  localparam int STATUS_OVF = 2;
endpackage

// File: rtl/ahb_switch_event_debounce.sv
// switch_debounce: 2-flop synchroniser plus stability counter producing a debounced level
module switch_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level
);
  localparam int W = $clog2(DEB_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(DEB_CYCLES - 1);
  logic [1:0] sync;
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], d};
      cnt <= (sync[1] == level || cnt == LAST) ? '0 : cnt + W'(1);
      if (sync[1] != level && cnt == LAST) level <= sync[1];
    end
  end
endmodule

// File: rtl/ahb_switch_event.sv
// ahb_switch_event: AHB-Lite slave debouncing switches, queueing edge events in a FIFO and raising an IRQ
module ahb_switch_event
  import ahb_switch_event_pkg::*;
#(
  parameter int N_IN = 8,
  parameter int DEB_CYCLES = 50000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            HSEL,
  input  logic [31:0]     HADDR,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic            HREADY,
  input  logic [31:0]     HWDATA,
  output logic [31:0]     HRDATA,
  output logic            HREADYOUT,
  input  logic [N_IN-1:0] SW_IN,
  output logic            irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [N_IN-1:0] lvl, lvl_q, ev, pend, pend_rise, eff, eff_rise;
  logic [2:0] ctrl;
  logic ovf, a_valid, a_write, rd, wr, empty, full, pop, push_req, push, sel_rise;
  logic [1:0] a_addr;
  logic [5:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0] mem [FIFO_DEPTH];
  logic [3:0] sel;
  logic unused_bits;
  for (genvar g = 0; g < N_IN; g++) begin : g_deb
    switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(HCLK),
      .rst(HRESET),
      .d(SW_IN[g]),
      .level(lvl[g])
    );
  end
  assign HREADYOUT = 1'b1;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:3]};
  assign ev = ((lvl & ~lvl_q) | (ctrl[CTRL_FALL_EN] ? (~lvl & lvl_q) : '0)) & {N_IN{ctrl[CTRL_EN]}};
  assign eff = (pend | ev) & {N_IN{ctrl[CTRL_EN]}};
  assign eff_rise = (ev & lvl) | (~ev & pend_rise);
  assign rd = a_valid & ~a_write;
  assign wr = a_valid & a_write;
  assign empty = count == 6'd0;
  assign full = count == 6'(FIFO_DEPTH);
  assign pop = rd & (a_addr == REG_DATA) & ~empty;
  assign push_req = |eff;
  assign push = push_req & (~full | pop);
  always_comb begin
    sel = '0;
    sel_rise = 1'b0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (eff[i]) begin
        sel = 4'(i);
        sel_rise = eff_rise[i];
      end
    end
  end
  always_comb begin
    HRDATA = !rd ? '0 :
             a_addr == REG_DATA ? (empty ? '0 : {22'b0, mem[rd_ptr][4], 1'b1, 4'b0, mem[rd_ptr][3:0]}) :
             a_addr == REG_STATUS ? {18'b0, count, 5'b0, ovf, full, empty} :
             a_addr == REG_CTRL ? {29'b0, ctrl} : 32'(lvl);
  end
  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= {sel_rise, sel};
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_addr <= '0;
      ctrl <= '0;
      ovf <= 1'b0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pend <= '0;
      pend_rise <= '0;
      lvl_q <= '0;
      irq <= 1'b0;
    end else begin
      a_valid <= HSEL & HREADY & HTRANS[1];
      a_write <= HWRITE;
      a_addr <= HADDR[3:2];
      lvl_q <= lvl;
      pend <= eff & ~(N_IN'(1) << sel);
      pend_rise <= eff_rise;
      if (wr && a_addr == REG_CTRL) ctrl <= HWDATA[2:0];
      ovf <= (push_req & full & ~pop) | (ovf & ~(wr & (a_addr == REG_STATUS) & HWDATA[STATUS_OVF]));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + 6'(push) - 6'(pop);
      irq <= ctrl[CTRL_IE] & (~empty | ovf);
    end
  end
endmodule

// File: tb/tb_ahb_switch_event.sv
// tb_ahb_switch_event: directed self-checking bench for ahb_switch_event with DEB_CYCLES=4
module tb_ahb_switch_event;
  logic HCLK = 1'b0;
  logic HRESET, HSEL, HWRITE, HREADY, HREADYOUT, irq;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0] HTRANS;
  logic [7:0] SW_IN;
  int passed = 0;
  int total = 0;
  ahb_switch_event #(.N_IN(8), .DEB_CYCLES(4), .FIFO_DEPTH(8)) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .HSEL(HSEL),
    .HADDR(HADDR),
    .HTRANS(HTRANS),
    .HWRITE(HWRITE),
    .HREADY(HREADY),
    .HWDATA(HWDATA),
    .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT),
    .SW_IN(SW_IN),
    .irq(irq)
  );
  always #5 HCLK = ~HCLK;
  task automatic tick(input int n);
    repeat (n) @(negedge HCLK);
  endtask
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0;
    HTRANS = 2'b00;
    d = HRDATA;
  endtask
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HWDATA = v;
  endtask
  task automatic toggle(input int b);
    SW_IN[b] = ~SW_IN[b];
    tick(10);
  endtask
  task automatic test_reset;
    logic [31:0] d;
    HRESET = 1'b1;
    tick(3);
    total++; if (HRDATA !== 32'h0) $display("FAIL rst_hrdata got %h want %h", HRDATA, 32'h0); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL rst_irq got %b want 0", irq); else passed++;
    total++; if (HREADYOUT !== 1'b1) $display("FAIL rst_hreadyout got %b want 1", HREADYOUT); else passed++;
    HRESET = 1'b0;
    bus_rd(32'hC, d);
    total++; if (d !== 32'h0) $display("FAIL rst_level got %h want %h", d, 32'h0); else passed++;
    bus_rd(32'h4, d);
    total++; if (d !== 32'h1) $display("FAIL rst_status got %h want %h", d, 32'h1); else passed++;
    bus_rd(32'h8, d);
    total++; if (d !== 32'h0) $display("FAIL rst_ctrl got %h want %h", d, 32'h0); else passed++;
  endtask
  task automatic test_rise_irq;
    logic [31:0] d;
    bus_wr(32'h8, 32'h3);
    SW_IN[2] = 1'b1;
    tick(4);
    bus_rd(32'hC, d);
    total++; if (d !== 32'h0) $display("FAIL deb_level_early got %h want %h", d, 32'h0); else passed++;
    bus_rd(32'hC, d);
    total++; if (d !== 32'h4) $display("FAIL deb_level got %h want %h", d, 32'h4); else passed++;
    tick(2);
    total++; if (irq !== 1'b1) $display("FAIL irq_rise got %b want 1", irq); else passed++;
    bus_rd(32'h0, d);
    total++; if (d !== 32'h302) $display("FAIL data_rise2 got %h want %h", d, 32'h302); else passed++;
    bus_rd(32'h4, d);
    total++; if (d !== 32'h1) $display("FAIL status_after_pop got %h want %h", d, 32'h1); else passed++;
    tick(1);
    total++; if (irq !== 1'b0) $display("FAIL irq_drop got %b want 0", irq); else passed++;
    total++; if (HREADYOUT !== 1'b1) $display("FAIL hreadyout got %b want 1", HREADYOUT); else passed++;
  endtask
  task automatic test_glitch;
    logic [31:0] d;
    SW_IN[5] = 1'b1;
    tick(2);
    SW_IN[5] = 1'b0;
    tick(12);
    bus_rd(32'hC, d);
    total++; if (d !== 32'h4) $display("FAIL glitch_level got %h want %h", d, 32'h4); else passed++;
    bus_rd(32'h4, d);
    total++; if (d !== 32'h1) $display("FAIL glitch_status got %h want %h", d, 32'h1); else passed++;
  endtask
  task automatic test_simultaneous;
    logic [31:0] d;
    bus_wr(32'h8, 32'h5);
    SW_IN[0] = 1'b1;
    SW_IN[3] = 1'b1;
    tick(12);
    total++; if (irq !== 1'b0) $display("FAIL irq_masked got %b want 0", irq); else passed++;
    bus_rd(32'h0, d);
    total++; if (d !== 32'h300) $display("FAIL data_bit0 got %h want %h", d, 32'h300); else passed++;
    bus_rd(32'h0, d);
    total++; if (d !== 32'h303) $display("FAIL data_bit3 got %h want %h", d, 32'h303); else passed++;
    bus_rd(32'h0, d);
    total++; if (d !== 32'h0) $display("FAIL data_empty got %h want %h", d, 32'h0); else passed++;
    SW_IN[0] = 1'b0;
    tick(12);
    bus_rd(32'h0, d);
    total++; if (d !== 32'h100) $display("FAIL data_fall0 got %h want %h", d, 32'h100); else passed++;
    bus_rd(32'hC, d);
    total++; if (d !== 32'hC) $display("FAIL level_after_fall got %h want %h", d, 32'hC); else passed++;
  endtask
  task automatic test_overflow;
    logic [31:0] d;
    int bits [9] = '{1, 4, 6, 7, 1, 4, 6, 7, 1};
    logic [31:0] exp [8] = '{32'h301, 32'h304, 32'h306, 32'h307, 32'h101, 32'h104, 32'h106, 32'h107};
    bus_wr(32'h8, 32'h7);
    for (int i = 0; i < 9; i++) toggle(bits[i]);
    bus_rd(32'h4, d);
    total++; if (d !== 32'h806) $display("FAIL ovf_status got %h want %h", d, 32'h806); else passed++;
    for (int i = 0; i < 8; i++) begin
      bus_rd(32'h0, d);
      total++; if (d !== exp[i]) $display("FAIL ovf_data%0d got %h want %h", i, d, exp[i]); else passed++;
    end
    bus_rd(32'h4, d);
    total++; if (d !== 32'h5) $display("FAIL ovf_drained got %h want %h", d, 32'h5); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL irq_ovf got %b want 1", irq); else passed++;
    bus_wr(32'h4, 32'h4);
    bus_rd(32'h4, d);
    total++; if (d !== 32'h1) $display("FAIL ovf_clear got %h want %h", d, 32'h1); else passed++;
    tick(1);
    total++; if (irq !== 1'b0) $display("FAIL irq_ovf_clear got %b want 0", irq); else passed++;
    bus_rd(32'hC, d);
    total++; if (d !== 32'hE) $display("FAIL ovf_level got %h want %h", d, 32'hE); else passed++;
  endtask
  task automatic test_back_to_back;
    logic [31:0] d;
    int bits [8] = '{4, 6, 7, 4, 6, 7, 5, 5};
    for (int i = 0; i < 8; i++) toggle(bits[i]);
    bus_rd(32'h4, d);
    total++; if (d !== 32'h802) $display("FAIL full_status got %h want %h", d, 32'h802); else passed++;
    SW_IN[0] = 1'b1;
    tick(5);
    bus_rd(32'h0, d);
    total++; if (d !== 32'h304) $display("FAIL pushpop_data got %h want %h", d, 32'h304); else passed++;
    bus_rd(32'h4, d);
    total++; if (d !== 32'h802) $display("FAIL pushpop_status got %h want %h", d, 32'h802); else passed++;
    bus_rd(32'h0, d);
    total++; if (d !== 32'h306) $display("FAIL pushpop_next got %h want %h", d, 32'h306); else passed++;
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR = 32'h0;
    @(negedge HCLK);
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    total++; if (HRDATA !== 32'h0) $display("FAIL midrst_hrdata got %h want %h", HRDATA, 32'h0); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL midrst_irq got %b want 0", irq); else passed++;
    bus_rd(32'h4, d);
    total++; if (d !== 32'h1) $display("FAIL midrst_status got %h want %h", d, 32'h1); else passed++;
    bus_rd(32'h8, d);
    total++; if (d !== 32'h0) $display("FAIL midrst_ctrl got %h want %h", d, 32'h0); else passed++;
    bus_rd(32'hC, d);
    total++; if (d !== 32'h0) $display("FAIL midrst_level got %h want %h", d, 32'h0); else passed++;
  endtask
  initial begin
    HRESET = 1'b1;
    HSEL = 1'b0;
    HADDR = '0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HREADY = 1'b1;
    HWDATA = '0;
    SW_IN = '0;
    test_reset();
    test_rise_irq();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
